// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer driving one shared WIDTH-bit adder, limbs LS-first.
// Latency: a limb accepted in cycle t is on out_sum in cycle t+1; done pulses the cycle after the last limb drains.
// Backpressure: one-entry output register; in_ready drops only while a result is held and out_ready is low.
// Optional: define MPADD_ZERO_DETECT_EN to build the sticky non-zero detector behind result_zero.
module mp_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int LIMBS = 32
) (
  input  logic             clk,
  input  logic             rst,
  // command / status
  input  logic             start,
  input  logic             op_sub,
  output logic             busy,
  output logic             done,
  output logic             carry_out,
  // operand limb stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  // shared adder
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  // result limb stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             result_zero
);

  // Counter wide enough to hold LIMBS itself; never overridden.
  localparam int CNT_W = $clog2(LIMBS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LIMBS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q;
  logic             op_sub_q;   // operation latched at start
  logic             carry_q;    // carry/not-borrow chained between limbs
  logic [CNT_W-1:0] count_q;    // index of the next limb to accept

  logic             accept;     // limb pair handshake this cycle
  logic             out_fire;   // result limb handshake this cycle
  logic             is_last;    // the limb being accepted is limb LIMBS-1

`ifdef MPADD_ZERO_DETECT_EN
  logic             nz_q;       // any result limb so far was non-zero
`endif

  // Status and handshake decode from the registered state.
  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign is_last  = (count_q == LAST_IDX);

  // Subtraction is A + ~B + 1: the initial carry_q of 1 supplies the +1.
  assign add_a   = in_a;
  assign add_b   = op_sub_q ? ~in_b : in_b;
  assign add_cin = carry_q;

`ifndef MPADD_ZERO_DETECT_EN
  assign result_zero = 1'b0;
`endif

  // Control FSM plus all registered outputs; done is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_sub_q  <= 1'b0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
`ifdef MPADD_ZERO_DETECT_EN
      nz_q        <= 1'b0;
      result_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse is dropped so the
          // sink sees done and the new operation in separate cycles.
          if (start && !done) begin
            op_sub_q <= op_sub;
            carry_q  <= op_sub;
            count_q  <= '0;
`ifdef MPADD_ZERO_DETECT_EN
            nz_q     <= 1'b0;
`endif
            state_q  <= RUN;
          end
        end

        RUN: begin
          if (accept) begin
            out_sum   <= add_sum;
            carry_q   <= add_cout;
            count_q   <= count_q + CNT_W'(1);
            out_valid <= 1'b1;
            out_last  <= is_last;
`ifdef MPADD_ZERO_DETECT_EN
            nz_q      <= nz_q | (|add_sum);
`endif
            if (is_last) begin
              state_q <= DRAIN;
            end
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
        end

        DRAIN: begin
          // Only the last limb can be pending here.
          if (out_fire) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done      <= 1'b1;
              carry_out <= carry_q;
`ifdef MPADD_ZERO_DETECT_EN
              result_zero <= !nz_q;
`endif
              state_q   <= IDLE;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A stalled result must not move or vanish.
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_sum) && $stable(out_last)));

  // done is a single-cycle pulse issued from IDLE.
  a_done_idle: assert property (@(posedge clk) disable iff (rst)
    done |-> (state_q == IDLE));
  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    done |=> !done);

  // No limb is taken outside RUN.
  a_no_accept_idle: assert property (@(posedge clk) disable iff (rst)
    !busy |-> !in_ready);

  // DRAIN always holds the final limb.
  a_drain_last: assert property (@(posedge clk) disable iff (rst)
    (state_q == DRAIN) |-> (out_valid && out_last));
`endif

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Testbench for mp_add_sequencer (LIMBS=4, WIDTH=32) against a big-integer reference model.
// Stimulus is directed plus randomized limb gaps and output stalls.
// Outputs are sampled 1 ns after the falling edge; inputs are driven from the same point.
`timescale 1ns/1ps
module tb_mp_add_sequencer;

  localparam int WIDTH = 32;
  localparam int LIMBS = 4;
  localparam int DW    = WIDTH * LIMBS;
`ifdef MPADD_ZERO_DETECT_EN
  localparam bit RZ_EN = 1'b1;
`else
  localparam bit RZ_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start, op_sub, busy, done, carry_out;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             out_valid, out_ready, out_last, result_zero;
  logic [WIDTH-1:0] out_sum;

  int n_checks = 0;
  int n_pass   = 0;

  // Results collected by run_op
  logic [WIDTH-1:0] r_sums[$];
  logic             r_lasts[$];
  logic             r_carry, r_rz, r_busy_after;
  int               r_done_cnt, r_viol_hold, r_viol_inrdy, r_viol_lat, r_viol_busy, r_stalled;
  bit               r_timeout;

  always #5 clk = ~clk;

  // The shared single-word adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  mp_add_sequencer #(.WIDTH(WIDTH), .LIMBS(LIMBS)) dut (
    .clk(clk), .rst(rst),
    .start(start), .op_sub(op_sub), .busy(busy), .done(done), .carry_out(carry_out),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
    .result_zero(result_zero)
  );

  // Reference: {carry or not-borrow, result mod 2^DW}
  function automatic logic [DW:0] model(input logic sub, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] r;
    if (sub) begin
      r[DW-1:0] = a - b;
      r[DW]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int k = 0; k < LIMBS; k++) v[k*WIDTH +: WIDTH] = $urandom;
    return v;
  endfunction

  // Drives one full operation and records what comes out. Entered and left just after a falling edge.
  task automatic run_op(input logic sub, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int stall_len, input bit rand_flow, input bit poke_busy, input bit start_at_done);
    int li, cyc, stall;
    bit seen_first, fin, prev_hold, prev_acc;
    logic [WIDTH-1:0] prev_sum;
    logic prev_last;
    r_sums.delete(); r_lasts.delete();
    r_done_cnt = 0; r_viol_hold = 0; r_viol_inrdy = 0; r_viol_lat = 0; r_viol_busy = 0;
    r_stalled = 0; r_timeout = 0; r_carry = 1'b0; r_rz = 1'b0; r_busy_after = 1'b1;
    li = 0; cyc = 0; stall = 0; seen_first = 0; fin = 0; prev_hold = 0; prev_acc = 0;
    prev_sum = '0; prev_last = 1'b0;
    while (!fin) begin
      start  = (cyc == 0) || (poke_busy && cyc == 3);
      op_sub = (cyc == 0) ? sub : ~sub;
      if (out_valid && !seen_first) begin
        seen_first = 1;
        stall = stall_len;
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = rand_flow ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (li < LIMBS) begin
        in_valid = !rand_flow || ($urandom_range(0, 3) != 0);
        in_a = a[li*WIDTH +: WIDTH];
        in_b = b[li*WIDTH +: WIDTH];
      end else begin
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
      end
      #1;
      if (prev_hold && (!out_valid || out_sum !== prev_sum || out_last !== prev_last)) r_viol_hold++;
      if (prev_acc && !out_valid) r_viol_lat++;
      if (out_valid && !out_ready && in_ready) r_viol_inrdy++;
      if (done) begin
        r_done_cnt++;
        r_carry = carry_out;
        r_rz = result_zero;
        fin = 1;
      end else if (cyc > 0 && !busy) begin
        r_viol_busy++;
      end
      if (out_valid && out_ready) begin
        r_sums.push_back(out_sum);
        r_lasts.push_back(out_last);
      end
      if (out_valid && !out_ready) r_stalled++;
      prev_acc = in_valid && in_ready;
      if (prev_acc) li++;
      prev_hold = out_valid && !out_ready;
      prev_sum = out_sum;
      prev_last = out_last;
      cyc++;
      if (!fin && cyc > 400) begin
        r_timeout = 1;
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
    // In the done cycle, optionally raise a start that must be ignored.
    start = start_at_done;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    r_busy_after = busy;
    if (done) r_done_cnt++;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; op_sub = 0; in_valid = 0; in_a = '0; in_b = '0; out_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, carry_out, in_ready, out_valid, out_last, result_zero} !== 7'b0)
      $display("FAIL reset_flags: got %b expected 0000000", {busy, done, carry_out, in_ready, out_valid, out_last, result_zero});
    else n_pass++;
    n_checks++;
    if (out_sum !== '0) $display("FAIL reset_out_sum: got %h expected 0", out_sum);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL idle_in_ready: got in_ready=%b busy=%b expected 0 0", in_ready, busy);
    else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_add_carry();
    logic [DW-1:0] a, b;
    logic [DW:0] e;
    logic [LIMBS-1:0] lv;
    a = '1; b = '0; b[0] = 1'b1;
    e = model(1'b0, a, b);
    run_op(1'b0, a, b, 0, 0, 0, 0);
    n_checks++;
    if (r_timeout || r_sums.size() != LIMBS) $display("FAIL add_count: got %0d limbs timeout=%0d expected %0d", r_sums.size(), r_timeout, LIMBS);
    else n_pass++;
    for (int i = 0; i < LIMBS; i++) begin
      n_checks++;
      if (r_sums[i] !== e[i*WIDTH +: WIDTH]) $display("FAIL add_sum[%0d]: got %h expected %h", i, r_sums[i], e[i*WIDTH +: WIDTH]);
      else n_pass++;
    end
    lv = '0;
    foreach (r_lasts[i]) if (i < LIMBS) lv[i] = r_lasts[i];
    n_checks++;
    if (lv !== (LIMBS'(1) << (LIMBS - 1))) $display("FAIL add_last: got %b expected %b", lv, LIMBS'(1) << (LIMBS - 1));
    else n_pass++;
    n_checks++;
    if (r_carry !== e[DW] || r_done_cnt != 1) $display("FAIL add_carry: got carry=%b done=%0d expected carry=%b done=1", r_carry, r_done_cnt, e[DW]);
    else n_pass++;
  endtask

  task automatic test_sub_underflow();
    logic [DW-1:0] a, b;
    logic [DW:0] e;
    a = '0; b = '0; b[0] = 1'b1;
    e = model(1'b1, a, b);
    run_op(1'b1, a, b, 0, 0, 0, 0);
    for (int i = 0; i < LIMBS; i++) begin
      n_checks++;
      if (r_sums[i] !== e[i*WIDTH +: WIDTH]) $display("FAIL under_sum[%0d]: got %h expected %h", i, r_sums[i], e[i*WIDTH +: WIDTH]);
      else n_pass++;
    end
    n_checks++;
    if (r_carry !== 1'b0 || r_rz !== 1'b0 || r_done_cnt != 1)
      $display("FAIL under_flags: got carry=%b zero=%b done=%0d expected 0 0 1", r_carry, r_rz, r_done_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b;
    logic [DW:0] e;
    a = rnd(); b = rnd();
    e = model(1'b0, a, b);
    run_op(1'b0, a, b, 3, 0, 0, 0);
    n_checks++;
    if (r_stalled < 3) $display("FAIL bp_stalled: got %0d stall cycles expected >=3", r_stalled);
    else n_pass++;
    n_checks++;
    if (r_viol_hold != 0 || r_viol_inrdy != 0 || r_viol_lat != 0)
      $display("FAIL bp_protocol: got hold=%0d inrdy=%0d lat=%0d expected 0 0 0", r_viol_hold, r_viol_inrdy, r_viol_lat);
    else n_pass++;
    n_checks++;
    if (r_sums.size() != LIMBS) $display("FAIL bp_count: got %0d expected %0d", r_sums.size(), LIMBS);
    else n_pass++;
    for (int i = 0; i < LIMBS; i++) begin
      n_checks++;
      if (r_sums[i] !== e[i*WIDTH +: WIDTH]) $display("FAIL bp_sum[%0d]: got %h expected %h", i, r_sums[i], e[i*WIDTH +: WIDTH]);
      else n_pass++;
    end
    n_checks++;
    if (r_carry !== e[DW]) $display("FAIL bp_carry: got %b expected %b", r_carry, e[DW]);
    else n_pass++;
  endtask

  task automatic test_sub_equal();
    logic [DW-1:0] a;
    for (int k = 0; k < LIMBS; k++) a[k*WIDTH +: WIDTH] = 32'h1234_5678;
    run_op(1'b1, a, a, 0, 0, 0, 0);
    for (int i = 0; i < LIMBS; i++) begin
      n_checks++;
      if (r_sums[i] !== '0) $display("FAIL eq_sum[%0d]: got %h expected 0", i, r_sums[i]);
      else n_pass++;
    end
    n_checks++;
    if (r_carry !== 1'b1 || r_rz !== RZ_EN)
      $display("FAIL eq_flags: got carry=%b zero=%b expected 1 %b", r_carry, r_rz, RZ_EN);
    else n_pass++;
    n_checks++;
    if (result_zero !== RZ_EN || carry_out !== 1'b1)
      $display("FAIL eq_hold: got zero=%b carry=%b expected %b 1", result_zero, carry_out, RZ_EN);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [DW-1:0] a, b;
    logic [DW:0] e;
    int dn;
    a = rnd(); b = rnd();
    start = 1'b1; op_sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_a = a[0 +: WIDTH]; in_b = b[0 +: WIDTH];
    @(negedge clk);
    in_a = a[WIDTH +: WIDTH]; in_b = b[WIDTH +: WIDTH];
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) $display("FAIL mid_progress: got busy=%b out_valid=%b expected 1 1", busy, out_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, carry_out, in_ready, out_valid, out_last, result_zero} !== 7'b0)
      $display("FAIL mid_reset_flags: got %b expected 0000000", {busy, done, carry_out, in_ready, out_valid, out_last, result_zero});
    else n_pass++;
    n_checks++;
    if (out_sum !== '0) $display("FAIL mid_reset_sum: got %h expected 0", out_sum);
    else n_pass++;
    dn = 0;
    repeat (3) begin @(negedge clk); #1; if (done) dn++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); #1; if (done || busy) dn++; end
    n_checks++;
    if (dn != 0) $display("FAIL mid_no_done: got %0d stray done/busy cycles expected 0", dn);
    else n_pass++;
    e = model(1'b0, a, b);
    run_op(1'b0, a, b, 0, 0, 0, 0);
    for (int i = 0; i < LIMBS; i++) begin
      n_checks++;
      if (r_sums[i] !== e[i*WIDTH +: WIDTH]) $display("FAIL mid_after_sum[%0d]: got %h expected %h", i, r_sums[i], e[i*WIDTH +: WIDTH]);
      else n_pass++;
    end
    n_checks++;
    if (r_carry !== e[DW] || r_done_cnt != 1) $display("FAIL mid_after_carry: got %b done=%0d expected %b 1", r_carry, r_done_cnt, e[DW]);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic [DW-1:0] a, b;
    logic [DW:0] e;
    a = rnd(); b = rnd();
    e = model(1'b1, a, b);
    run_op(1'b1, a, b, 0, 0, 1, 1);
    for (int i = 0; i < LIMBS; i++) begin
      n_checks++;
      if (r_sums[i] !== e[i*WIDTH +: WIDTH]) $display("FAIL ign_sum[%0d]: got %h expected %h", i, r_sums[i], e[i*WIDTH +: WIDTH]);
      else n_pass++;
    end
    n_checks++;
    if (r_done_cnt != 1 || r_busy_after !== 1'b0 || r_carry !== e[DW])
      $display("FAIL ign_done_start: got done=%0d busy_after=%b carry=%b expected 1 0 %b", r_done_cnt, r_busy_after, r_carry, e[DW]);
    else n_pass++;
    // Next start issued the very next cycle.
    a = rnd(); b = rnd();
    e = model(1'b0, a, b);
    run_op(1'b0, a, b, 0, 0, 0, 0);
    for (int i = 0; i < LIMBS; i++) begin
      n_checks++;
      if (r_sums[i] !== e[i*WIDTH +: WIDTH]) $display("FAIL next_sum[%0d]: got %h expected %h", i, r_sums[i], e[i*WIDTH +: WIDTH]);
      else n_pass++;
    end
    n_checks++;
    if (r_done_cnt != 1 || r_carry !== e[DW] || r_timeout) $display("FAIL next_done: got done=%0d carry=%b expected 1 %b", r_done_cnt, r_carry, e[DW]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b;
    logic [DW:0] e;
    logic sub;
    for (int n = 0; n < 12; n++) begin
      a = rnd(); b = rnd();
      if (n % 4 == 0) b = a;
      sub = $urandom_range(0, 1);
      e = model(sub, a, b);
      run_op(sub, a, b, $urandom_range(0, 3), 1, 0, 0);
      n_checks++;
      if (r_timeout || r_sums.size() != LIMBS) $display("FAIL rnd%0d_count: got %0d limbs timeout=%0d expected %0d", n, r_sums.size(), r_timeout, LIMBS);
      else n_pass++;
      for (int i = 0; i < LIMBS; i++) begin
        n_checks++;
        if (r_sums[i] !== e[i*WIDTH +: WIDTH] || r_lasts[i] !== (i == LIMBS - 1))
          $display("FAIL rnd%0d_sum[%0d]: got %h last=%b expected %h last=%b", n, i, r_sums[i], r_lasts[i], e[i*WIDTH +: WIDTH], (i == LIMBS - 1));
        else n_pass++;
      end
      n_checks++;
      if (r_carry !== e[DW] || r_rz !== (RZ_EN && (e[DW-1:0] == '0)) || r_done_cnt != 1)
        $display("FAIL rnd%0d_flags: got carry=%b zero=%b done=%0d expected %b %b 1", n, r_carry, r_rz, r_done_cnt, e[DW], RZ_EN && (e[DW-1:0] == '0));
      else n_pass++;
      n_checks++;
      if (r_viol_hold != 0 || r_viol_inrdy != 0 || r_viol_lat != 0 || r_viol_busy != 0)
        $display("FAIL rnd%0d_protocol: got hold=%0d inrdy=%0d lat=%0d busy=%0d expected all 0", n, r_viol_hold, r_viol_inrdy, r_viol_lat, r_viol_busy);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_underflow();
    test_backpressure();
    test_sub_equal();
    test_reset_mid_run();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
